// File: rtl/serializer_arb.sv
// Round-robin arbiter feeding a shared serializer from NUM_REQ one-entry request buffers.
// Optional macro SERIALIZER_ARB_MOD_FILTER_EN drops words whose bit count is 1 or 2.
module serializer_arb #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_BUS_WIDTH = 16,
  parameter int unsigned DATA_MOD_WIDTH = 5
) (
  input  logic                               clk_i,
  input  logic                               arst_ni,
  input  logic [NUM_REQ*DATA_BUS_WIDTH-1:0]  req_data_i,
  input  logic [NUM_REQ*DATA_MOD_WIDTH-1:0]  req_mod_i,
  input  logic [NUM_REQ-1:0]                 req_val_i,
  output logic [NUM_REQ-1:0]                 req_ready_o,
  output logic [DATA_BUS_WIDTH-1:0]          ser_data_o,
  output logic [DATA_MOD_WIDTH-1:0]          ser_mod_o,
  output logic                               ser_val_o,
  input  logic                               ser_busy_i,
  output logic [$clog2(NUM_REQ)-1:0]         grant_id_o,
  output logic                               drop_o
);

  localparam int unsigned GrantW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {StArb, StIssue, StWaitStart, StWaitDone} state_e;

  state_e                    state_q, state_d;
  logic [NUM_REQ-1:0]        buf_valid_q, buf_valid_d;
  logic [DATA_BUS_WIDTH-1:0] buf_data_q [NUM_REQ];
  logic [DATA_MOD_WIDTH-1:0] buf_mod_q [NUM_REQ];
  logic [GrantW-1:0]         last_grant_q, last_grant_d;
  logic [GrantW-1:0]         grant_q, grant_d;
  logic [DATA_BUS_WIDTH-1:0] ser_data_q, ser_data_d;
  logic [DATA_MOD_WIDTH-1:0] ser_mod_q, ser_mod_d;
  logic                      wait_cnt_q, wait_cnt_d;
  logic                      ready_en_q;
  logic [NUM_REQ-1:0]        accept;
  logic [NUM_REQ-1:0]        filt;
  logic [GrantW-1:0]         rr_win;
  logic                      rr_found;
  int unsigned               rr_idx;

  // Ready is held low while in reset and for the remainder of the release cycle.
  assign req_ready_o = ready_en_q ? ~buf_valid_q : '0;
  assign accept      = req_val_i & req_ready_o;
  assign ser_val_o   = (state_q == StIssue);
  assign ser_data_o  = ser_data_q;
  assign ser_mod_o   = ser_mod_q;
  assign grant_id_o  = grant_q;

`ifdef SERIALIZER_ARB_MOD_FILTER_EN
  logic drop_q;

  always_comb begin
    filt = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      filt[i] = (req_mod_i[i*DATA_MOD_WIDTH +: DATA_MOD_WIDTH] == DATA_MOD_WIDTH'(1)) ||
                (req_mod_i[i*DATA_MOD_WIDTH +: DATA_MOD_WIDTH] == DATA_MOD_WIDTH'(2));
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) drop_q <= 1'b0;
    else          drop_q <= |(accept & filt);
  end

  assign drop_o = drop_q;
`else
  assign filt   = '0;
  assign drop_o = 1'b0;
`endif

  // Search starts one past the last grant so every pending channel is served in turn.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = '0;
    rr_idx   = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      rr_idx = (32'(last_grant_q) + 32'd1 + k) % NUM_REQ;
      if (!rr_found && buf_valid_q[GrantW'(rr_idx)]) begin
        rr_found = 1'b1;
        rr_win   = GrantW'(rr_idx);
      end
    end
  end

  always_comb begin
    buf_valid_d = buf_valid_q | (accept & ~filt);
    if (state_q == StIssue) buf_valid_d[grant_q] = 1'b0;
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    ser_data_d   = ser_data_q;
    ser_mod_d    = ser_mod_q;
    wait_cnt_d   = 1'b0;
    unique case (state_q)
      StArb: begin
        if (!ser_busy_i && rr_found) begin
          grant_d    = rr_win;
          ser_data_d = buf_data_q[rr_win];
          ser_mod_d  = buf_mod_q[rr_win];
          state_d    = StIssue;
        end
      end
      StIssue: begin
        last_grant_d = grant_q;
        state_d      = StWaitStart;
      end
      StWaitStart: begin
        // Two idle cycles without busy means the serializer ignored the word.
        if (ser_busy_i)      state_d    = StWaitDone;
        else if (wait_cnt_q) state_d    = StArb;
        else                 wait_cnt_d = 1'b1;
      end
      StWaitDone: begin
        if (!ser_busy_i) state_d = StArb;
      end
      default: state_d = StArb;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q      <= StArb;
      buf_valid_q  <= '0;
      last_grant_q <= GrantW'(NUM_REQ - 1);
      grant_q      <= '0;
      ser_data_q   <= '0;
      ser_mod_q    <= '0;
      wait_cnt_q   <= 1'b0;
      ready_en_q   <= 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        buf_data_q[i] <= '0;
        buf_mod_q[i]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      buf_valid_q  <= buf_valid_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      ser_data_q   <= ser_data_d;
      ser_mod_q    <= ser_mod_d;
      wait_cnt_q   <= wait_cnt_d;
      ready_en_q   <= 1'b1;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (accept[i]) begin
          buf_data_q[i] <= req_data_i[i*DATA_BUS_WIDTH +: DATA_BUS_WIDTH];
          buf_mod_q[i]  <= req_mod_i[i*DATA_MOD_WIDTH +: DATA_MOD_WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_serializer_arb.sv
// Directed bench for serializer_arb: table of single-word transfers plus hand-written
// sequences for fairness, busy hold-off, ignored-word timeout / filtering and reset.
module tb_serializer_arb;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int MW = 5;

  logic             clk = 1'b0;
  logic             arst_n = 1'b1;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR*MW-1:0] req_mod = '0;
  logic [NR-1:0]    req_val = '0;
  logic [NR-1:0]    req_ready;
  logic [DW-1:0]    ser_data;
  logic [MW-1:0]    ser_mod;
  logic             ser_val;
  logic             ser_busy;
  logic [1:0]       grant;
  logic             drop;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serializer_arb #(
    .NUM_REQ       (NR),
    .DATA_BUS_WIDTH(DW),
    .DATA_MOD_WIDTH(MW)
  ) dut (
    .clk_i      (clk),
    .arst_ni    (arst_n),
    .req_data_i (req_data),
    .req_mod_i  (req_mod),
    .req_val_i  (req_val),
    .req_ready_o(req_ready),
    .ser_data_o (ser_data),
    .ser_mod_o  (ser_mod),
    .ser_val_o  (ser_val),
    .ser_busy_i (ser_busy),
    .grant_id_o (grant),
    .drop_o     (drop)
  );

  // Serializer model: busy rises the cycle after a ser_val pulse and lasts busy_len cycles.
  logic busy_man = 1'b0;
  int   busy_len = 0;
  int   busy_cnt = 0;
  int   val_count = 0;

  always @(posedge clk) begin
    if (ser_val) begin
      val_count <= val_count + 1;
      busy_cnt  <= busy_len;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  assign ser_busy = busy_man | (busy_cnt > 0);

  typedef struct {
    int         ch;
    logic [15:0] data;
    logic [4:0]  mod;
    int          blen;
    logic [1:0]  exp_grant;
    logic [15:0] exp_data;
    logic [4:0]  exp_mod;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_val = '0;
    arst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #3 arst_n = 1'b1;
    tick();
  endtask

  task automatic load(input int ch, input logic [15:0] data, input logic [4:0] mod);
    req_data[ch*DW +: DW] = data;
    req_mod[ch*MW +: MW]  = mod;
    req_val[ch]           = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int       base;
    bit       found;
    int       got;
    int       p1_k, p2_k;
    logic [1:0] p1_g, p2_g;
    logic [15:0] p2_d;

    vecs[0] = '{ch: 0, data: 16'hA5C3, mod: 5'd0,  blen: 16, exp_grant: 2'd0,
                exp_data: 16'hA5C3, exp_mod: 5'd0};
    vecs[1] = '{ch: 2, data: 16'h1234, mod: 5'd7,  blen: 3,  exp_grant: 2'd2,
                exp_data: 16'h1234, exp_mod: 5'd7};
    vecs[2] = '{ch: 3, data: 16'hFFFF, mod: 5'd16, blen: 1,  exp_grant: 2'd3,
                exp_data: 16'hFFFF, exp_mod: 5'd16};
    vecs[3] = '{ch: 1, data: 16'h0F0F, mod: 5'd31, blen: 5,  exp_grant: 2'd1,
                exp_data: 16'h0F0F, exp_mod: 5'd31};

    // Reset values while reset is held
    #2 arst_n = 1'b0;
    #1;
    check("rst ready", 64'(req_ready), 64'h0);
    check("rst ser_val", 64'(ser_val), 64'h0);
    check("rst ser_data", 64'(ser_data), 64'h0);
    check("rst ser_mod", 64'(ser_mod), 64'h0);
    check("rst grant", 64'(grant), 64'h0);
    check("rst drop", 64'(drop), 64'h0);
    @(posedge clk);
    @(posedge clk);
    #3 arst_n = 1'b1;
    #1;
    check("ready before first edge", 64'(req_ready), 64'h0);
    tick();
    check("ready after first edge", 64'(req_ready), 64'hF);

    // Table of single-word transfers
    for (int v = 0; v < 4; v++) begin
      busy_len = vecs[v].blen;
      load(vecs[v].ch, vecs[v].data, vecs[v].mod);
      tick();
      req_val = '0;
      check("vec ready low while buffered", 64'(req_ready[vecs[v].ch]), 64'h0);
      base  = val_count;
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
        tick();
        if (ser_val) found = 1'b1;
      end
      check("vec issue seen", 64'(found), 64'h1);
      if (found) begin
        check("vec grant", 64'(grant), 64'(vecs[v].exp_grant));
        check("vec data", 64'(ser_data), 64'(vecs[v].exp_data));
        check("vec mod", 64'(ser_mod), 64'(vecs[v].exp_mod));
        tick();
        check("vec single pulse", 64'(ser_val), 64'h0);
        check("vec ready after issue", 64'(req_ready[vecs[v].ch]), 64'h1);
        check("vec data held", 64'(ser_data), 64'(vecs[v].exp_data));
      end
      repeat (vecs[v].blen + 6) tick();
      check("vec pulse count", 64'(val_count - base), 64'h1);
    end

    // Fairness with all channels continuously valid
    do_reset();
    busy_len = 2;
    for (int i = 0; i < NR; i++) load(i, 16'h1000 + 16'(i), 5'd0);
    got = 0;
    for (int c = 0; c < 200 && got < 6; c++) begin
      tick();
      if (ser_val) begin
        check("rr grant", 64'(grant), 64'(got % 4));
        check("rr data", 64'(ser_data), 64'(16'h1000 + 16'(got % 4)));
        got++;
      end
    end
    check("rr grant count", 64'(got), 64'd6);
    req_val = '0;

    // Busy held high blocks issue; issue follows quickly once it falls
    do_reset();
    busy_len = 0;
    busy_man = 1'b1;
    load(2, 16'hBEEF, 5'd3);
    tick();
    req_val = '0;
    base = val_count;
    repeat (50) tick();
    check("busy hold no issue", 64'(val_count - base), 64'h0);
    check("busy hold ser_val low", 64'(ser_val), 64'h0);
    busy_man = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 2 && !found; k++) begin
      tick();
      if (ser_val) found = 1'b1;
    end
    check("busy release issue", 64'(found), 64'h1);
    check("busy release grant", 64'(grant), 64'h2);
    check("busy release data", 64'(ser_data), 64'hBEEF);
    repeat (6) tick();

    // Ignored word / filter: last grant is 2, so ch3 goes first, then ch1 (mod 2)
    load(1, 16'h2222, 5'd2);
    load(3, 16'h3333, 5'd0);
    tick();
    req_val = '0;
`ifdef SERIALIZER_ARB_MOD_FILTER_EN
    check("filter drop pulse", 64'(drop), 64'h1);
`else
    check("no filter drop", 64'(drop), 64'h0);
`endif
    p1_k = -1; p2_k = -1; p1_g = '0; p2_g = '0; p2_d = '0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 1) check("drop is one cycle", 64'(drop), 64'h0);
      if (ser_val) begin
        if (p1_k < 0) begin
          p1_k = k; p1_g = grant;
        end else if (p2_k < 0) begin
          p2_k = k; p2_g = grant; p2_d = ser_data;
        end
      end
    end
    check("timeout first issue cycle", 64'(p1_k), 64'd1);
    check("timeout first grant", 64'(p1_g), 64'd3);
`ifdef SERIALIZER_ARB_MOD_FILTER_EN
    check("filtered word never issued", 64'(p2_k), 64'(-1));
`else
    check("timeout second issue cycle", 64'(p2_k), 64'd5);
    check("timeout second grant", 64'(p2_g), 64'd1);
    check("timeout second data", 64'(p2_d), 64'h2222);
`endif

    // Reset during WAIT_DONE discards ch3
    do_reset();
    busy_len = 20;
    load(0, 16'hCAFE, 5'd4);
    load(3, 16'hD00D, 5'd6);
    tick();
    req_val = '0;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      tick();
      if (ser_val) found = 1'b1;
    end
    check("rst seq first issue", 64'(found), 64'h1);
    check("rst seq first grant", 64'(grant), 64'h0);
    repeat (5) tick();
    #2 arst_n = 1'b0;
    #1;
    check("mid rst ser_val", 64'(ser_val), 64'h0);
    check("mid rst ser_data", 64'(ser_data), 64'h0);
    check("mid rst ser_mod", 64'(ser_mod), 64'h0);
    check("mid rst grant", 64'(grant), 64'h0);
    check("mid rst ready", 64'(req_ready), 64'h0);
    base = val_count;
    #2 arst_n = 1'b1;
    repeat (40) tick();
    check("no issue after reset", 64'(val_count - base), 64'h0);
    check("ready after reset", 64'(req_ready), 64'hF);
    check("data stays cleared", 64'(ser_data), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
